// File: rtl/z80_mmu_paged.sv
// Paged Z80 MMU: maps the top address bits through a bank register file and drives the ROM/RAM enables.
// It also provides per-page write protect, a key-sequence lock on the map and a saturating write-fault counter.
module z80_mmu_paged #(
    parameter int          PAGE_BITS = 3,
    parameter int          BANK_W    = 5,
    parameter int          ROM_BANKS = 1,
    parameter logic [7:0]  MAP_BASE  = 8'hD8,
    parameter logic [7:0]  CTRL_PORT = 8'hD1
) (
    input  logic                 clkout,
    input  logic                 reset,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic                 iorq_n,
    input  logic                 mreq_n,
    input  logic [7:0]           a_lo,
    input  logic [PAGE_BITS-1:0] a_hi,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic                 romen_n,
    output logic                 ramen_n,
    output logic [BANK_W-1:0]    bank_out,
    output logic                 locked,
    output logic                 wp_fault
);

    localparam int NPAGES = 1 << PAGE_BITS;
    localparam int EW     = BANK_W + 1;
    localparam logic [BANK_W:0] ROM_LIM = (BANK_W+1)'(ROM_BANKS);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_KEY1
    } lock_state_e;

    // Each entry is {wp, bank}.
    logic [EW-1:0]  entry_q [NPAGES];
    logic [EW-1:0]  entry_d [NPAGES];
    lock_state_e    state_q, state_d;
    logic [7:0]     fault_cnt_q, fault_cnt_d;
    logic           io_done_q, io_done_d;
    logic           mem_done_q, mem_done_d;
    logic           wp_fault_q, wp_fault_d;

    logic                 map_sel, ctrl_sel, map_rd, ctrl_rd;
    logic                 map_wr, ctrl_wr, mem_wr, fault, cnt_clear;
    logic [PAGE_BITS-1:0] sel_idx;
    logic [EW-1:0]        sel_entry;
    logic                 sel_wp, is_rom;
    logic [BANK_W-1:0]    sel_bank;

    always_comb begin
        map_sel   = ~iorq_n && (a_lo[7:PAGE_BITS] == MAP_BASE[7:PAGE_BITS]);
        ctrl_sel  = ~iorq_n && (a_lo == CTRL_PORT);
        map_rd    = map_sel & ~rd_n;
        ctrl_rd   = ctrl_sel & ~rd_n;
        sel_idx   = map_rd ? a_lo[PAGE_BITS-1:0] : a_hi;
        sel_entry = entry_q[sel_idx];
        sel_wp    = sel_entry[BANK_W];
        sel_bank  = sel_entry[BANK_W-1:0];
        is_rom    = {1'b0, sel_bank} < ROM_LIM;
    end

    assign bank_out = sel_bank;
    assign romen_n  = mreq_n | ~is_rom;
    assign ramen_n  = mreq_n | is_rom | (sel_wp & ~wr_n);
    assign locked   = (state_q != ST_UNLOCKED);
    assign wp_fault = wp_fault_q;

    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        if (map_rd) begin
            data_oe              = 1'b1;
            data_out[7]          = sel_wp;
            data_out[BANK_W-1:0] = sel_bank;
        end else if (ctrl_rd) begin
            data_oe  = 1'b1;
            data_out = fault_cnt_q;
        end
    end

    // Done flags make each strobe act once, however many clkout edges it spans.
    always_comb begin
        map_wr     = ~iorq_n & ~wr_n & ~io_done_q & map_sel;
        ctrl_wr    = ~iorq_n & ~wr_n & ~io_done_q & ctrl_sel;
        io_done_d  = ~iorq_n & (io_done_q | map_wr | ctrl_wr);
        mem_wr     = ~mreq_n & ~wr_n & ~mem_done_q;
        mem_done_d = ~mreq_n & (mem_done_q | mem_wr);
        fault      = mem_wr & sel_wp & ~is_rom;
        wp_fault_d = fault;
    end

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        state_d   = state_q;
        cnt_clear = 1'b0;
        if (ctrl_wr) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (data_in == 8'h00)      state_d   = ST_LOCKED;
                    else if (data_in == 8'hC0) cnt_clear = 1'b1;
                end
                ST_LOCKED:   if (data_in == 8'hA5) state_d = ST_KEY1;
                ST_KEY1:     state_d = (data_in == 8'h5A) ? ST_UNLOCKED : ST_LOCKED;
                default:     state_d = ST_LOCKED;
            endcase
        end
    end

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (cnt_clear)                        fault_cnt_d = 8'h00;
        else if (fault && fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'h01;
    end

    always_comb begin
        for (int p = 0; p < NPAGES; p++) entry_d[p] = entry_q[p];
        if (map_wr && state_q == ST_UNLOCKED)
            entry_d[a_lo[PAGE_BITS-1:0]] = {data_in[7], data_in[BANK_W-1:0]};
    end

    always_ff @(posedge clkout or negedge reset) begin
        if (!reset) begin
            // NOTE: the map is a small flop register file, not RAM, so every entry takes its identity value on reset.
            for (int p = 0; p < NPAGES; p++) entry_q[p] <= {1'b0, BANK_W'(p)};
            state_q     <= ST_UNLOCKED;
            fault_cnt_q <= 8'h00;
            io_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            wp_fault_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking '<=' so all flops update from the same pre-edge values.
            for (int p = 0; p < NPAGES; p++) entry_q[p] <= entry_d[p];
            state_q     <= state_d;
            fault_cnt_q <= fault_cnt_d;
            io_done_q   <= io_done_d;
            mem_done_q  <= mem_done_d;
            wp_fault_q  <= wp_fault_d;
        end
    end

endmodule

// File: tb/tb_z80_mmu_paged.sv
// Self-checking bench for z80_mmu_paged: directed test-plan steps, then random bus traffic
// compared against a page-table / lock / counter model kept in the bench.
module tb_z80_mmu_paged;

    localparam int PAGE_BITS = 3;
    localparam int BANK_W    = 5;
    localparam int ROM_BANKS = 1;
    localparam int NPAGES    = 8;

    logic       clkout = 1'b0;
    logic       reset  = 1'b0;
    logic       rd_n = 1'b1, wr_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1;
    logic [7:0] a_lo = 8'h00;
    logic [2:0] a_hi = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe, romen_n, ramen_n, locked, wp_fault;
    logic [4:0] bank_out;

    int checks = 0;
    int errors = 0;

    // Reference model: page table, lock status and fault counter.
    int  m_bank [NPAGES];
    bit  m_wp   [NPAGES];
    bit  m_locked;
    bit  m_armed;
    int  m_cnt;

    z80_mmu_paged #(
        .PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W), .ROM_BANKS(ROM_BANKS),
        .MAP_BASE(8'hD8), .CTRL_PORT(8'hD1)
    ) dut (
        .clkout(clkout), .reset(reset), .rd_n(rd_n), .wr_n(wr_n),
        .iorq_n(iorq_n), .mreq_n(mreq_n), .a_lo(a_lo), .a_hi(a_hi),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .romen_n(romen_n), .ramen_n(ramen_n), .bank_out(bank_out),
        .locked(locked), .wp_fault(wp_fault)
    );

    always #5 clkout = ~clkout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NPAGES; p++) begin
            m_bank[p] = p % 32;
            m_wp[p]   = 1'b0;
        end
        m_locked = 1'b0;
        m_armed  = 1'b0;
        m_cnt    = 0;
    endfunction

    function automatic logic [7:0] model_entry(input int p);
        return {m_wp[p], 2'b00, 5'(m_bank[p])};
    endfunction

    function automatic void model_io_write(input logic [7:0] addr, input logic [7:0] d);
        if (addr[7:3] == 5'b11011) begin
            if (!m_locked) begin
                m_wp[addr[2:0]]   = d[7];
                m_bank[addr[2:0]] = int'(d[4:0]);
            end
        end else if (addr == 8'hD1) begin
            if (!m_locked) begin
                if (d == 8'h00)      m_locked = 1'b1;
                else if (d == 8'hC0) m_cnt = 0;
            end else if (!m_armed) begin
                m_armed = (d == 8'hA5);
            end else begin
                m_armed = 1'b0;
                if (d == 8'h5A) m_locked = 1'b0;
            end
        end
    endfunction

    task automatic io_write(input logic [7:0] addr, input logic [7:0] d, input int hold);
        @(negedge clkout);
        a_lo = addr; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(posedge clkout);
        @(negedge clkout);
        iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge clkout);
        model_io_write(addr, d);
    endtask

    task automatic io_read_check(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        @(negedge clkout);
        a_lo = addr; iorq_n = 1'b0; rd_n = 1'b0;
        #2;
        check(tag, data_out, exp);
        check({tag, "_oe"}, data_oe, 1'b1);
        @(negedge clkout);
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic mem_read_check(input int p, input string tag);
        bit rom;
        rom = m_bank[p] < ROM_BANKS;
        @(negedge clkout);
        a_hi = 3'(p); mreq_n = 1'b0; rd_n = 1'b0;
        #2;
        check({tag, "_bank"}, bank_out, m_bank[p]);
        check({tag, "_romen"}, romen_n, !rom);
        check({tag, "_ramen"}, ramen_n, rom);
        @(negedge clkout);
        mreq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic mem_write_check(input int p, input string tag);
        bit rom, flt;
        int pulses;
        rom = m_bank[p] < ROM_BANKS;
        flt = m_wp[p] && !rom;
        pulses = 0;
        @(negedge clkout);
        a_hi = 3'(p); mreq_n = 1'b0; wr_n = 1'b0;
        #2;
        check({tag, "_wr_ramen"}, ramen_n, rom || m_wp[p]);
        check({tag, "_wr_romen"}, romen_n, !rom);
        repeat (3) begin
            @(posedge clkout);
            @(negedge clkout);
            pulses += int'(wp_fault);
        end
        mreq_n = 1'b1; wr_n = 1'b1;
        @(posedge clkout);
        @(negedge clkout);
        pulses += int'(wp_fault);
        check({tag, "_pulses"}, pulses, flt);
        if (flt && m_cnt < 255) m_cnt++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clkout);
        reset = 1'b1;
        @(negedge clkout);

        check("rst_locked", locked, 1'b0);
        check("rst_wp_fault", wp_fault, 1'b0);
        check("rst_data_oe", data_oe, 1'b0);
        io_read_check(8'hD8, 8'h00, "rst_d8");
        io_read_check(8'hD9, 8'h01, "rst_d9");
        mem_read_check(0, "rst_page0");

        io_write(8'hDA, 8'h87, 2);
        io_read_check(8'hDA, 8'h87, "map_da");
        mem_write_check(2, "wp_page2");
        io_read_check(8'hD1, 8'h01, "cnt_one");

        io_write(8'hD1, 8'h00, 2);
        check("lock_on", locked, 1'b1);
        io_write(8'hDB, 8'h05, 2);
        io_read_check(8'hDB, 8'h03, "locked_db");

        io_write(8'hD1, 8'hA5, 2);
        io_write(8'hD1, 8'h5A, 2);
        check("unlock_key", locked, 1'b0);

        io_write(8'hD1, 8'h00, 2);
        io_write(8'hD1, 8'hA5, 2);
        io_write(8'hD1, 8'h33, 2);
        io_write(8'hD1, 8'h5A, 2);
        check("bad_key", locked, 1'b1);
        io_write(8'hD1, 8'hA5, 2);
        io_write(8'hD1, 8'h5A, 2);
        check("unlock_again", locked, 1'b0);

        // A long strobe must count as one write: a repeated A5 would fall back to LOCKED.
        io_write(8'hD1, 8'h00, 1);
        io_write(8'hD1, 8'hA5, 10);
        io_write(8'hD1, 8'h5A, 1);
        check("single_accept", locked, m_locked);
        check("single_accept_unl", locked, 1'b0);

        for (int i = 0; i < 300; i++) mem_write_check(2, "sat_run");
        io_read_check(8'hD1, 8'hFF, "cnt_sat");
        io_write(8'hD1, 8'hC0, 2);
        io_read_check(8'hD1, 8'h00, "cnt_clear");

        // Reset arriving in the middle of a held, locked map write.
        io_write(8'hDC, 8'h8A, 2);
        io_read_check(8'hDC, 8'h8A, "map_dc");
        io_write(8'hD1, 8'h00, 2);
        @(negedge clkout);
        a_hi = 3'd4; a_lo = 8'hDC; data_in = 8'h1F; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge clkout);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check("midrst_bank4", bank_out, 5'd4);
        check("midrst_locked", locked, 1'b0);
        check("midrst_fault", wp_fault, 1'b0);
        @(negedge clkout);
        reset = 1'b1;
        repeat (3) @(posedge clkout);
        @(negedge clkout);
        iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge clkout);
        model_io_write(8'hDC, 8'h1F);
        io_read_check(8'hDC, 8'h1F, "postrst_dc");
        io_read_check(8'hD1, 8'h00, "postrst_cnt");

        for (int i = 0; i < 250; i++) begin
            int op, p;
            logic [7:0] d;
            op = $urandom_range(0, 5);
            p  = $urandom_range(0, NPAGES - 1);
            d  = 8'($urandom);
            case (op)
                0: io_write({5'b11011, 3'(p)}, d, $urandom_range(1, 4));
                1: begin
                    case ($urandom_range(0, 4))
                        0: d = 8'h00;
                        1: d = 8'hA5;
                        2: d = 8'h5A;
                        3: d = 8'hC0;
                        default: ;
                    endcase
                    io_write(8'hD1, d, $urandom_range(1, 4));
                    check("rnd_locked", locked, m_locked);
                end
                2: mem_write_check(p, "rnd_mw");
                3: io_read_check({5'b11011, 3'(p)}, model_entry(p), "rnd_map");
                4: io_read_check(8'hD1, 8'(m_cnt), "rnd_cnt");
                default: mem_read_check(p, "rnd_mr");
            endcase
        end
        for (int p = 0; p < NPAGES; p++) io_read_check({5'b11011, 3'(p)}, model_entry(p), "final_map");
        io_read_check(8'hD1, 8'(m_cnt), "final_cnt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
